wb_stage: RTL and testbench

Pipelined, parametrised writeback stage for the miniRV core. Accepts retiring instructions from the MEM stage through a valid/ready handshake, and holds them in an in-order queue until any outstanding load data returns from data memory. It aligns and extends load data, selects the final result (ALU / load / LUI / PC+4), and drives a registered register-file write port.

---
 rtl/wb_stage.sv | 175 +++++++++++++++++
 tb/tb_wb_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// miniRV writeback stage: in-order retire queue, load-response FIFO with same-cycle bypass,
// load alignment and registered register-file write port. Define WB_SUBWORD_EN for lb/lh/lhu support.
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned RD_W  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alures,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [RD_W-1:0] in_rd,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_data,
  output logic            rf_we,
  output logic [RD_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic            proto_err
);

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_LOAD = 2'd1,
    KIND_LUI  = 2'd2,
    KIND_JUMP = 2'd3
  } kind_t;

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  kind_t           q_kind    [DEPTH];
  logic [2:0]      q_funct3  [DEPTH];
  logic [1:0]      q_addr_lo [DEPTH];
  logic [RD_W-1:0] q_rd      [DEPTH];
  logic [XLEN-1:0] q_opnd    [DEPTH];
  logic [PW-1:0]   q_head, q_tail;
  logic [CW-1:0]   q_count;

  logic [XLEN-1:0] r_data [DEPTH];
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count;

  logic [CW-1:0]   loads_outstanding;

  kind_t           in_kind_e;
  logic            enq;
  logic            rsp_accept;
  logic            head_valid;
  logic            head_load;
  logic            retire;
  logic            bypass;
  logic            rsp_push;
  logic            rsp_pop;
  logic [XLEN-1:0] load_word;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] enq_opnd;

  function automatic logic [XLEN-1:0] align_load(
    input logic [XLEN-1:0] w,
    input logic [2:0]      f3,
    input logic [1:0]      off
  );
    logic [7:0] b;
`ifdef WB_SUBWORD_EN
    logic [15:0] h;
`endif
    b = w[int'(off)*8 +: 8];
`ifdef WB_SUBWORD_EN
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  align_load = {{(XLEN-8){b[7]}}, b};
      3'b001:  align_load = {{(XLEN-16){h[15]}}, h};
      3'b100:  align_load = {{(XLEN-8){1'b0}}, b};
      3'b101:  align_load = {{(XLEN-16){1'b0}}, h};
      default: align_load = w;
    endcase
`else
    align_load = (f3 == 3'b100) ? {{(XLEN-8){1'b0}}, b} : w;
`endif
  endfunction

  assign in_ready = (q_count < DEPTH_C);
  assign busy     = (q_count != '0);

  always_comb begin
    in_kind_e  = kind_t'(in_kind);
    enq        = in_valid && in_ready;
    rsp_accept = rsp_valid && (loads_outstanding != '0);
    head_valid = (q_count != '0);
    head_load  = head_valid && (q_kind[q_head] == KIND_LOAD);
    // A load head takes the oldest buffered word first; a same-cycle word is only
    // consumed directly when nothing older is buffered, which keeps response order.
    retire     = head_valid && (!head_load || (r_count != '0) || rsp_accept);
    bypass     = head_load && (r_count == '0) && rsp_accept;
    rsp_push   = rsp_accept && !bypass;
    rsp_pop    = head_load && (r_count != '0);
    load_word  = (r_count != '0) ? r_data[r_head] : rsp_data;
    result     = head_load ? align_load(load_word, q_funct3[q_head], q_addr_lo[q_head])
                           : q_opnd[q_head];
    case (in_kind_e)
      KIND_LUI:  enq_opnd = in_imm;
      KIND_JUMP: enq_opnd = in_pc4;
      default:   enq_opnd = in_alures;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_kind[i]    <= KIND_ALU;
        q_funct3[i]  <= '0;
        q_addr_lo[i] <= '0;
        q_rd[i]      <= '0;
        q_opnd[i]    <= '0;
        r_data[i]    <= '0;
      end
      q_head            <= '0;
      q_tail            <= '0;
      q_count           <= '0;
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      loads_outstanding <= '0;
      rf_we             <= 1'b0;
      rf_waddr          <= '0;
      rf_wdata          <= '0;
      proto_err         <= 1'b0;
    end else begin
      if (enq) begin
        q_kind[q_tail]    <= in_kind_e;
        q_funct3[q_tail]  <= in_funct3;
        q_addr_lo[q_tail] <= in_addr_lo;
        q_rd[q_tail]      <= in_rd;
        q_opnd[q_tail]    <= enq_opnd;
        q_tail            <= q_tail + PW'(1);
      end
      if (retire) begin
        q_head <= q_head + PW'(1);
      end
      q_count <= q_count + CW'(enq) - CW'(retire);

      if (rsp_push) begin
        r_data[r_tail] <= rsp_data;
        r_tail         <= r_tail + PW'(1);
      end
      if (rsp_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(rsp_push) - CW'(rsp_pop);

      loads_outstanding <= loads_outstanding
                         + CW'(enq && (in_kind_e == KIND_LOAD))
                         - CW'(rsp_accept);

      if (rsp_valid && (loads_outstanding == '0)) begin
        proto_err <= 1'b1;
      end

      rf_we <= retire && (q_rd[q_head] != '0);
      if (retire) begin
        rf_waddr <= q_rd[q_head];
        rf_wdata <= result;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed scenarios plus randomized traffic against a queue-level model.
module tb_wb_stage;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int RD_W  = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_kind;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lo;
  logic [XLEN-1:0] in_alures;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_pc4;
  logic [RD_W-1:0] in_rd;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rf_we;
  logic [RD_W-1:0] rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            busy;
  logic            proto_err;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
    .in_alures(in_alures), .in_imm(in_imm), .in_pc4(in_pc4), .in_rd(in_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_load;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          done;
  } ent_t;

  ent_t        pend[$];
  logic [4:0]  exp_rd[$];
  logic [31:0] exp_d[$];
  int          m_out = 0;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] b;
    b = (w >> (8 * off)) & 32'hFF;
`ifdef WB_SUBWORD_EN
    begin
      logic [31:0] h;
      h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
      case (f3)
        3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
        3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
        3'd4:    return b;
        3'd5:    return h;
        default: return w;
      endcase
    end
`else
    return (f3 == 3'd4) ? b : w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Write monitor: every rf_we must match the next expected write in program order.
  logic [4:0]  mon_rd;
  logic [31:0] mon_d;
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        mon_rd = exp_rd.pop_front();
        mon_d  = exp_d.pop_front();
        if (rf_waddr !== mon_rd || rf_wdata !== mon_d) begin
          errors++;
          $display("FAIL wr_data: got addr=%0d data=%h, required addr=%0d data=%h",
                   rf_waddr, rf_wdata, mon_rd, mon_d);
        end
      end
    end
  end

  task automatic idle_inputs();
    in_valid = 1'b0; in_kind = '0; in_funct3 = '0; in_addr_lo = '0;
    in_alures = '0; in_imm = '0; in_pc4 = '0; in_rd = '0;
    rsp_valid = 1'b0; rsp_data = '0;
  endtask

  task automatic put(input logic [1:0] k, input logic [2:0] f3, input logic [1:0] off,
                     input logic [4:0] rd, input logic [31:0] a, input logic [31:0] im,
                     input logic [31:0] p4);
    in_valid = 1'b1; in_kind = k; in_funct3 = f3; in_addr_lo = off;
    in_rd = rd; in_alures = a; in_imm = im; in_pc4 = p4;
  endtask

  task automatic rsp(input logic [31:0] d);
    rsp_valid = 1'b1; rsp_data = d;
  endtask

  // Apply the current inputs for one clock, updating the model with what the DUT accepts.
  task automatic tick();
    bit   fire, acc;
    ent_t e;
    fire = in_valid && in_ready;
    acc  = rsp_valid && (m_out > 0);
    if (acc) begin
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].is_load && !pend[i].done) begin
          pend[i].val  = ref_load(rsp_data, pend[i].f3, pend[i].off);
          pend[i].done = 1'b1;
          break;
        end
      end
      m_out--;
    end
    if (fire) begin
      e.is_load = (in_kind == 2'd1);
      e.f3      = in_funct3;
      e.off     = in_addr_lo;
      e.rd      = in_rd;
      e.val     = (in_kind == 2'd0) ? in_alures : (in_kind == 2'd2) ? in_imm :
                  (in_kind == 2'd3) ? in_pc4 : 32'h0;
      e.done    = !e.is_load;
      pend.push_back(e);
      if (e.is_load) m_out++;
    end
    while (pend.size() > 0 && pend[0].done) begin
      if (pend[0].rd != 0) begin
        exp_rd.push_back(pend[0].rd);
        exp_d.push_back(pend[0].val);
      end
      void'(pend.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic model_clear();
    pend.delete(); exp_rd.delete(); exp_d.delete(); m_out = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);

    put(2'd0, 3'd0, 2'd0, 5'd5, 32'h1234_5678, 32'h0, 32'h0); tick();
    tick();
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd5);
    chk("alu_wdata", rf_wdata, 32'h1234_5678);
    put(2'd0, 3'd0, 2'd0, 5'd0, 32'h1234_5678, 32'h0, 32'h0); tick();
    tick();
    chk("alu_rd0_we", 32'(rf_we), 32'd0);

    put(2'd1, 3'b100, 2'd2, 5'd6, 32'h0, 32'h0, 32'h0); tick();
    rsp(32'hAABB_CCDD); tick();
    chk("lbu_we", 32'(rf_we), 32'd1);
    chk("lbu_wdata", rf_wdata, 32'h0000_00BB);
`ifdef WB_SUBWORD_EN
    put(2'd1, 3'b000, 2'd3, 5'd7, 32'h0, 32'h0, 32'h0); tick();
    rsp(32'hAABB_CCDD); tick();
    chk("lb_wdata", rf_wdata, 32'hFFFF_FFAA);
    put(2'd1, 3'b001, 2'd2, 5'd7, 32'h0, 32'h0, 32'h0); tick();
    rsp(32'hAABB_CCDD); tick();
    chk("lh_wdata", rf_wdata, 32'hFFFF_AABB);
    put(2'd1, 3'b101, 2'd0, 5'd7, 32'h0, 32'h0, 32'h0); tick();
    rsp(32'hAABB_CCDD); tick();
    chk("lhu_wdata", rf_wdata, 32'h0000_CCDD);
`endif

    put(2'd1, 3'b010, 2'd0, 5'd1, 32'h0, 32'h0, 32'h0); tick();
    chk("ord_hold0", 32'(rf_we), 32'd0);
    put(2'd0, 3'd0, 2'd0, 5'd2, 32'hCAFE_0002, 32'h0, 32'h0); tick();
    chk("ord_hold1", 32'(rf_we), 32'd0);
    put(2'd2, 3'd0, 2'd0, 5'd3, 32'h0, 32'h0001_2000, 32'h0); tick();
    chk("ord_hold2", 32'(rf_we), 32'd0);
    tick(); chk("ord_hold3", 32'(rf_we), 32'd0);
    tick(); chk("ord_hold4", 32'(rf_we), 32'd0);
    rsp(32'h0BAD_F00D); tick();
    chk("ord_w1", {rf_we, 26'd0, rf_waddr}, {1'b1, 26'd0, 5'd1});
    tick();
    chk("ord_w2", {rf_we, 26'd0, rf_waddr}, {1'b1, 26'd0, 5'd2});
    tick();
    chk("ord_w3", {rf_we, 26'd0, rf_waddr}, {1'b1, 26'd0, 5'd3});
    chk("ord_lui", rf_wdata, 32'h0001_2000);

    for (int i = 0; i < DEPTH; i++) begin
      put(2'd1, 3'b010, 2'd0, 5'(4 + i), 32'h0, 32'h0, 32'h0); tick();
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      rsp($urandom); tick();
      chk("b2b_waddr", {rf_we, 26'd0, rf_waddr}, {1'b1, 26'd0, 5'(4 + i)});
    end
    chk("drained_in_ready", 32'(in_ready), 32'd1);
    chk("drained_busy", 32'(busy), 32'd0);

    for (int i = 0; i < DEPTH; i++) begin
      put(2'd1, 3'b010, 2'd0, 5'(12 + i), 32'h0, 32'h0, 32'h0); tick();
    end
    put(2'd3, 3'd0, 2'd0, 5'd1, 32'h0, 32'h0, 32'h0000_0104); tick();
    put(2'd3, 3'd0, 2'd0, 5'd1, 32'h0, 32'h0, 32'h0000_0104); rsp($urandom); tick();
    chk("jmp_ready_after_retire", 32'(in_ready), 32'd1);
    put(2'd3, 3'd0, 2'd0, 5'd1, 32'h0, 32'h0, 32'h0000_0104); rsp($urandom); tick();
    chk("jmp_enq_retire_ready", 32'(in_ready), 32'd1);
    put(2'd0, 3'd0, 2'd0, 5'd20, 32'hA5A5_5A5A, 32'h0, 32'h0); tick();
    chk("jmp_count_full", 32'(in_ready), 32'd0);
    rsp($urandom); tick();
    rsp($urandom); tick();
    tick();
    chk("jmp_wdata", rf_wdata, 32'h0000_0104);
    tick();
    chk("jmp_busy", 32'(busy), 32'd0);

    chk("proto_clear", 32'(proto_err), 32'd0);
    rsp(32'hDEAD_BEEF); tick();
    chk("proto_set", 32'(proto_err), 32'd1);
    tick(); tick();
    chk("proto_sticky", 32'(proto_err), 32'd1);

    put(2'd1, 3'b010, 2'd0, 5'd9, 32'h0, 32'h0, 32'h0); tick();
    put(2'd1, 3'b100, 2'd1, 5'd10, 32'h0, 32'h0, 32'h0); tick();
    put(2'd0, 3'd0, 2'd0, 5'd11, 32'h1111_1111, 32'h0, 32'h0); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(rf_we), 32'd0);
    chk("midrst_waddr", 32'(rf_waddr), 32'd0);
    chk("midrst_wdata", rf_wdata, 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_proto", 32'(proto_err), 32'd0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick(); tick();
    rsp(32'h5555_AAAA); tick();
    chk("post_rst_stale_rsp", 32'(proto_err), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) < 6) begin
        logic [2:0] f3s [8];
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        put(2'($urandom_range(0, 3)), f3s[$urandom_range(0, 7)], 2'($urandom),
            5'($urandom), $urandom, $urandom, $urandom);
      end
      if (m_out > 0 && $urandom_range(0, 1) == 1) rsp($urandom);
      tick();
    end
    for (int c = 0; c < 300 && pend.size() > 0; c++) begin
      if (m_out > 0) rsp($urandom);
      tick();
    end
    tick(); tick(); tick();
    chk("final_pending", 32'(pend.size()), 32'd0);
    chk("final_exp_empty", 32'(exp_rd.size()), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
